// File: rtl/uart_fmt_pkg.sv
// Shared definitions for the DHT reading line formatter: FSM states, ASCII
// constants and line lengths.
package uart_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SEND,
        ST_FIN
    } state_e;

    localparam logic [7:0] ASC_H   = 8'h48;
    localparam logic [7:0] ASC_T   = 8'h54;
    localparam logic [7:0] ASC_EQ  = 8'h3D;
    localparam logic [7:0] ASC_PCT = 8'h25;
    localparam logic [7:0] ASC_SP  = 8'h20;
    localparam logic [7:0] ASC_C   = 8'h43;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_0   = 8'h30;

    localparam int unsigned LEN_CRLF = 15;
    localparam int unsigned LEN_LF   = 14;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASC_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational double-dabble: 8-bit unsigned binary to three BCD digits
// {hundreds, tens, units}.
module bin2bcd8 (
    input  logic [7:0]  bin_i,
    output logic [11:0] bcd_o
);

    always_comb begin
        logic [19:0] sh;
        sh = {12'd0, bin_i};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        bcd_o = sh[19:8];
    end

endmodule

// File: rtl/dht_uart_reporter.sv
// Formats one humidity/temperature reading as "H=hhh% T=tttC" plus line end
// and pushes it byte-by-byte into the UART TX FIFO, honouring tx_full.
module dht_uart_reporter
    import uart_fmt_pkg::*;
#(
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic       tx_full,
    output logic       push,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = EOL_CRLF ? 4'(LEN_CRLF - 1) : 4'(LEN_LF - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  hum_q, hum_d, tmp_q, tmp_d;
    logic [11:0] hbcd_q, hbcd_d, tbcd_q, tbcd_d;
    logic [11:0] hbcd_w, tbcd_w;

    bin2bcd8 u_hum_bcd (.bin_i(hum_q), .bcd_o(hbcd_w));
    bin2bcd8 u_tmp_bcd (.bin_i(tmp_q), .bcd_o(tbcd_w));

    function automatic logic [7:0] line_byte(input logic [3:0] i,
                                             input logic [11:0] h,
                                             input logic [11:0] t);
        case (i)
            4'd0:    return ASC_H;
            4'd1:    return ASC_EQ;
            4'd2:    return ascii_digit(h[11:8]);
            4'd3:    return ascii_digit(h[7:4]);
            4'd4:    return ascii_digit(h[3:0]);
            4'd5:    return ASC_PCT;
            4'd6:    return ASC_SP;
            4'd7:    return ASC_T;
            4'd8:    return ASC_EQ;
            4'd9:    return ascii_digit(t[11:8]);
            4'd10:   return ascii_digit(t[7:4]);
            4'd11:   return ascii_digit(t[3:0]);
            4'd12:   return ASC_C;
            4'd13:   return EOL_CRLF ? ASC_CR : ASC_LF;
            4'd14:   return ASC_LF;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            hum_q   <= 8'd0;
            tmp_q   <= 8'd0;
            hbcd_q  <= 12'd0;
            tbcd_q  <= 12'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hum_q   <= hum_d;
            tmp_q   <= tmp_d;
            hbcd_q  <= hbcd_d;
            tbcd_q  <= tbcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hum_d   = hum_q;
        tmp_d   = tmp_q;
        hbcd_d  = hbcd_q;
        tbcd_d  = tbcd_q;
        push    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hum_d   = humidity;
                    tmp_d   = temperature;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                hbcd_d  = hbcd_w;
                tbcd_d  = tbcd_w;
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Stall without advancing while the FIFO is full so no byte is dropped.
                if (!tx_full) begin
                    push  = 1'b1;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign tx_data = (state_q == ST_SEND) ? line_byte(idx_q, hbcd_q, tbcd_q) : 8'h00;

endmodule

// File: doc/dht_uart_reporter.md
# dht_uart_reporter

Formats one DHT humidity/temperature reading as a fixed-length ASCII line and pushes it byte-by-byte into the UART transmit FIFO. It sits directly upstream of the UART top: its `push`/`tx_data` drive the TX FIFO push side, and it obeys that FIFO's `tx_full` back-pressure. A single `start` pulse from the sensor controller produces one complete line, for example `H=045% T=023C\r\n`.

## Interface
Parameters:
- `EOL_CRLF`, default 1: 1 ends each line with CR LF (15 bytes); 0 ends it with LF only (14 bytes).

Ports:
- `clk` input 1: system clock (100 MHz).
- `rst` input 1: reset, synchronous, active-low.
- `start` input 1: one-cycle request to report the current reading.
- `humidity` input 8: unsigned binary, 0–255.
- `temperature` input 8: unsigned binary, 0–255.
- `tx_full` input 1: TX FIFO full flag.
- `push` output 1: TX FIFO push strobe.
- `tx_data` output 8: byte presented with `push`.
- `busy` output 1: a line is in progress.
- `done` output 1: one-cycle pulse after the last byte is pushed.

## Operation
- **FSM states:** IDLE, CONV, SEND, FIN.
- **IDLE:**
  - `start`=1 latches `humidity` and `temperature` into internal registers.
  - Transition to CONV.
  - `start` is ignored in all other states; requests are not queued.
- **CONV:**
  - Registers the 3-digit BCD of both latched values, producing 6 digits, each 0–9.
  - Clears the byte index to 0.
  - Transition to SEND.
- **SEND:**
  - Byte index `idx` runs 0..LEN-1.
  - LEN = 15 if `EOL_CRLF`=1, otherwise 14.
  - Byte sequence: 'H'(0x48), '='(0x3D), Hh, Ht, Hu, '%'(0x25), ' '(0x20), 'T'(0x54), '='(0x3D), Th, Tt, Tu, 'C'(0x43), then CR(0x0D) if `EOL_CRLF`=1, then LF(0x0A).
  - Each digit byte = 0x30 + BCD digit. Leading zeros are always printed.
  - In each cycle with `tx_full`=0: `push`=1, `tx_data`=byte[idx], and `idx` increments.
  - In each cycle with `tx_full`=1: `push`=0 and `idx` holds. The stall length is unbounded.
  - The cycle that pushes byte LEN-1 transitions to FIN.
- **FIN:** `done`=1 for exactly one cycle, then return to IDLE.
- **Output behaviour:**
  - `push` is combinational from state and `tx_full`. It never asserts while `tx_full`=1, so no byte is ever lost.
  - `tx_data` is combinational from `idx` and the BCD registers. It is don't-care when `push`=0, but must not be X.
- **Reset:**
  - `rst`=0 at any clock edge forces IDLE, `idx`=0, and clears the latched values and BCD registers.
  - A partially sent line is abandoned; its remaining bytes are never pushed.
  - Reset values: `push`=0, `tx_data`=0x00, `busy`=0, `done`=0.

## Timing
- Cycle 0: `start`=1 sampled in IDLE.
- Cycle 1: CONV; `busy`=1, `push`=0.
- Cycle 2: SEND begins; the first push occurs here if `tx_full`=0.
- Unstalled line: pushes fill cycles 2..LEN+1, and `done` pulses in cycle LEN+2.
- Each stall cycle delays every later event by one cycle.
- `busy` = 1 in CONV, SEND and FIN; 0 in IDLE.
- The earliest next accepted `start` is the cycle after FIN.
- A `start` arriving in the same cycle as `done` is ignored.
- BCD arithmetic: value 0–255 converts to hundreds 0–2, tens 0–9, units 0–9.

## Structure
- Shared package `uart_fmt_pkg`:
  - FSM state enum.
  - ASCII constants: 'H', 'T', '=', '%', ' ', 'C', CR, LF, '0'.
  - Line-length constants 15 and 14.
- Sub-module `bin2bcd8`:
  - Combinational double-dabble.
  - 8-bit binary in, 12-bit BCD out (3 digits).
  - Instantiated twice; the results are registered in CONV.

## Test plan
- **Nominal line:** hum=45, temp=23, `tx_full`=0, `EOL_CRLF`=1, `start` pulse → bytes 48 3D 30 34 35 25 20 54 3D 30 32 33 43 0D 0A in 15 consecutive `push` cycles starting cycle 2; `done` in cycle 17.
- **Extremes, LF only:** hum=0, temp=255, `EOL_CRLF`=0 → "H=000% T=255C\n", 14 bytes, last byte 0x0A, no 0x0D.
- **Back-pressure:** `tx_full`=1 during byte indices 3 and 10, for 4 cycles each → `push`=0 throughout every full cycle; sequence identical to the nominal line; `done` delayed by 8 cycles.
- **Ignored start:** extra `start` pulses with new values during SEND and in the `done` cycle → the line in progress is unchanged, and no second line is produced.
- **Reset mid-line:** `rst`=0 after 6 bytes are pushed → `push`/`busy`/`done`=0 next cycle, `tx_data`=0x00; a following `start` with hum=99, temp=7 emits the full line "H=099% T=007C\r\n".
- **FIFO-full at start:** `tx_full`=1 from before `start` for 20 cycles → no push during the stall; the first byte 0x48 is pushed in the first cycle `tx_full` drops.
